ram_fill_dump_ctrl: RTL

RAM_FILL_DUMP_CTRL -- requirements
Module: ram_fill_dump_ctrl

---
 rtl/ram_fill_dump_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ram_fill_dump_ctrl.sv
// ram_fill_dump_ctrl: streams words into an external RAM, then plays the
// stored words back on request (valid/ready) and re-arms for the next fill.
// Optional build macro RAM_CTRL_CLEAR_EN: after each dump, zero the whole
// RAM (one address per cycle) before accepting new writes.
module ram_fill_dump_ctrl #(
  parameter int DW = 8,
  parameter int m  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          dump_req,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [m-1:0]  ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic [m:0]    count,
  output logic          full,
  output logic          busy
);

  // DEPTH expressed at count width so a full RAM is representable
  localparam logic [m:0] DEPTH_W = {1'b1, {m{1'b0}}};

`ifdef RAM_CTRL_CLEAR_EN
  typedef enum logic [1:0] {LOAD, DUMP, CLEAR} state_t;
`else
  typedef enum logic {LOAD, DUMP} state_t;
`endif

  state_t       state, state_nxt;
  logic [m-1:0] wr_ptr, wr_ptr_nxt;
  logic [m-1:0] rd_ptr, rd_ptr_nxt;
  logic [m:0]   cnt, cnt_nxt;
  logic [m:0]   dump_len, dump_len_nxt;
  logic [m:0]   cnt_post;
  logic         wr_fire;
  logic         rd_last;
`ifdef RAM_CTRL_CLEAR_EN
  logic [m-1:0] clr_ptr, clr_ptr_nxt;
`endif

  assign count = cnt;
  assign full  = (cnt == DEPTH_W);
  assign busy  = (state != LOAD);

  // State and pointer registers; reset aborts any dump/clear in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      dump_len <= '0;
`ifdef RAM_CTRL_CLEAR_EN
      clr_ptr  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      cnt      <= cnt_nxt;
      dump_len <= dump_len_nxt;
`ifdef RAM_CTRL_CLEAR_EN
      clr_ptr  <= clr_ptr_nxt;
`endif
    end
  end

  // Next-state and all RAM/stream outputs; RAM read is async so out_data
  // follows rd_ptr with no extra latency
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    cnt_nxt      = cnt;
    dump_len_nxt = dump_len;
`ifdef RAM_CTRL_CLEAR_EN
    clr_ptr_nxt  = clr_ptr;
`endif
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    ram_we       = 1'b0;
    ram_din      = '0;
    ram_addr     = wr_ptr;
    wr_fire      = 1'b0;
    cnt_post     = cnt;
    rd_last      = 1'b0;

    case (state)
      LOAD: begin
        // Once full, in_valid is ignored: no write, no pointer wrap
        in_ready = (cnt < DEPTH_W);
        wr_fire  = in_valid && (cnt < DEPTH_W);
        if (wr_fire) begin
          ram_we     = 1'b1;
          ram_din    = in_data;
          wr_ptr_nxt = wr_ptr + m'(1);
          cnt_post   = cnt + (m+1)'(1);
        end
        cnt_nxt = cnt_post;
        // Dump length uses the post-write count so a same-cycle word is
        // included; an empty RAM makes the request a no-op
        if (dump_req && (cnt_post != '0)) begin
          dump_len_nxt = cnt_post;
          rd_ptr_nxt   = '0;
          state_nxt    = DUMP;
        end
      end

      DUMP: begin
        ram_addr  = rd_ptr;
        out_valid = 1'b1;
        out_data  = ram_dout;
        rd_last   = ({1'b0, rd_ptr} == (dump_len - (m+1)'(1)));
        if (out_ready) begin
          if (rd_last) begin
            cnt_nxt    = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
`ifdef RAM_CTRL_CLEAR_EN
            clr_ptr_nxt = '0;
            state_nxt   = CLEAR;
`else
            state_nxt   = LOAD;
`endif
          end else begin
            rd_ptr_nxt = rd_ptr + m'(1);
          end
        end
      end

`ifdef RAM_CTRL_CLEAR_EN
      CLEAR: begin
        // Zero one address per cycle; exactly DEPTH cycles
        ram_addr    = clr_ptr;
        ram_we      = 1'b1;
        ram_din     = '0;
        clr_ptr_nxt = clr_ptr + m'(1);
        if (clr_ptr == {m{1'b1}}) state_nxt = LOAD;
      end
`endif

      default: state_nxt = LOAD;
    endcase
  end

  // Structural invariants
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= DEPTH_W);
  a_no_we_dump: assert property (@(posedge clk) disable iff (rst) !(out_valid && ram_we));
  a_no_rdy_busy: assert property (@(posedge clk) disable iff (rst) !(busy && in_ready));

endmodule
